// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/DIV sequencer that owns the HI/LO architectural registers.
// Latency: MULT/MULTU busy MULT_CYCLES cycles, DIV/DIVU busy DIV_CYCLES cycles; MTHI/MTLO visible next cycle.
// Backpressure: no handshake; out_stall freezes the F/D stages while a result is pending, so a start in RUN is never issued.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears HI/LO and aborts any operation
//   in_start    E-stage MD instruction valid (already qualified by stall/flush)
//   in_op       0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no effect
//   in_rs_data  forwarded rs operand
//   in_rt_data  forwarded rt operand
//   in_md_use   D-stage instruction touches the MD unit or HI/LO
//   out_busy    operation in flight (registered)
//   out_stall   hazard stall request (combinational)
//   out_done    one-cycle pulse in the cycle after the commit edge (registered)
//   out_hi      current HI register
//   out_lo      current LO register
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic        in_md_use,
  output logic        out_busy,
  output logic        out_stall,
  output logic        out_done,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [1:0]    op_q;      // bit1: divide, bit0: unsigned
  logic [31:0]   rs_q;
  logic [31:0]   rt_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic          busy_q;
  logic          done_q;

  // Result datapath, evaluated from the latched operands
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   mul_p;
  logic          div_neg_a;
  logic          div_neg_b;
  logic [31:0]   div_mag_a;
  logic [31:0]   div_mag_b;
  logic [31:0]   div_den;
  logic          div_by_zero;
  logic [31:0]   div_q_mag;
  logic [31:0]   div_r_mag;
  logic [31:0]   div_quo;
  logic [31:0]   div_rem;
  logic [31:0]   hi_d;
  logic [31:0]   lo_d;
  logic          wr_d;

  always_comb begin
    // Extending both operands to 64 bits (sign- or zero-extended) makes the
    // low 64 bits of an unsigned multiply equal the signed product too.
    mul_a = {{32{~op_q[0] & rs_q[31]}}, rs_q};
    mul_b = {{32{~op_q[0] & rt_q[31]}}, rt_q};
    mul_p = mul_a * mul_b;

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend's sign. 0x80000000 / -1 falls out as
    // 0x80000000 r 0 without a special case.
    div_neg_a   = ~op_q[0] & rs_q[31];
    div_neg_b   = ~op_q[0] & rt_q[31];
    div_mag_a   = div_neg_a ? (32'd0 - rs_q) : rs_q;
    div_mag_b   = div_neg_b ? (32'd0 - rt_q) : rt_q;
    div_by_zero = (rt_q == 32'd0);
    // Keep the divider free of x/0; the result is discarded in that case.
    div_den     = div_by_zero ? 32'd1 : div_mag_b;
    div_q_mag   = div_mag_a / div_den;
    div_r_mag   = div_mag_a % div_den;
    div_quo     = (div_neg_a ^ div_neg_b) ? (32'd0 - div_q_mag) : div_q_mag;
    div_rem     = div_neg_a ? (32'd0 - div_r_mag) : div_r_mag;

    hi_d = mul_p[63:32];
    lo_d = mul_p[31:0];
    wr_d = 1'b1;
    if (op_q[1]) begin
      hi_d = div_rem;
      lo_d = div_quo;
      // Divide by zero spends the full latency but leaves HI/LO untouched.
      wr_d = ~div_by_zero;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_start) begin
            case (in_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q    <= in_op[1:0];
                rs_q    <= in_rs_data;
                rt_q    <= in_rt_data;
                cnt_q   <= in_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              3'd4:    hi_q <= in_rs_data;
              3'd5:    lo_q <= in_rs_data;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Starts arriving here are dropped; the stall contract prevents them.
          if (cnt_q == CW'(1)) begin
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The in_start term covers the start cycle itself, before out_busy rises.
  assign out_stall = in_md_use & (busy_q | (in_start & ~in_op[2]));
  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the five-stage pipeline. Accepts one MD operation per start from the E stage, owns the HI/LO architectural registers, and models MULT/DIV latency with a cycle counter. Drives the busy and stall signals the hazard logic uses to freeze the F/D stages while an MD result is pending. Commits results to HI/LO only on the final cycle of an operation.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- in_start  in  1  E-stage MD instruction valid, already qualified by the pipeline's stall/flush
- in_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored (no effect)
- in_rs_data  in  32  forwarded rs operand
- in_rt_data  in  32  forwarded rt operand
- in_md_use  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- out_busy  out  1  operation in flight (registered)
- out_stall  out  1  in_md_use & (out_busy | (in_start & in_op ≤ 3)); combinational
- out_done  out  1  one-cycle pulse on the commit cycle (registered)
- out_hi  out  32  current HI register
- out_lo  out  32  current LO register

## Operation
- States: IDLE, RUN. Reset → IDLE; out_busy=0, out_done=0, out_hi=0, out_lo=0, counter=0.
- IDLE, in_start, op 0–3: latch op, rs, rt; counter ← MULT_CYCLES or DIV_CYCLES; → RUN.
- IDLE, in_start, op 4/5: HI ← rs (MTHI) or LO ← rs (MTLO) at that edge; stay IDLE; no busy, no done.
- RUN: counter decrements each edge; at the edge where counter==1: write HI/LO, counter ← 0, → IDLE, out_done=1 for the following cycle.
- in_start while RUN: ignored (stall contract guarantees it cannot occur); bench flags it as an assertion.
- Arithmetic on latched operands:
  - MULT: 64-bit signed product; HI=[63:32], LO=[31:0].
  - MULTU: 64-bit unsigned product.
  - DIV: LO=quotient truncated toward zero, HI=remainder with dividend's sign; 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divisor 0 (DIV/DIVU): full latency spent, out_done pulses, HI/LO unchanged.
- out_hi/out_lo hold old values throughout RUN; MFHI/MFLO cannot read them early because out_stall holds the reader in D.
- Asynchronous reset mid-RUN: operation aborted, HI/LO cleared, IDLE immediately.

## Timing
- Start sampled at edge k → out_busy high from k to k+N (exactly N cycles), HI/LO updated at edge k+N, out_done high during cycle k+N to k+N+1, out_busy low in the same cycle.
- A new start is accepted at edge k+N (same edge as the commit) only if the FSM is IDLE there; it is not, so the earliest back-to-back start is edge k+N+1... correction: the commit edge transitions to IDLE, so next start is sampled at edge k+N+1 at the earliest. Throughput: one op per N+1 cycles max.
- out_stall asserts combinationally in the cycle of in_start (op 0–3) if in_md_use, covering the edge before out_busy rises.
- MTHI/MTLO: value visible on out_hi/out_lo one cycle after the start edge.

## Test plan
- Reset: hold reset=0 mid-DIV (cycle 4 of 10) → out_busy=0, out_hi=out_lo=0 immediately; no out_done after release.
- MULT rs=0xFFFFFFFF, rt=2 → out_busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE, out_done single pulse; MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero with HI=0x1234, LO=0x5678 preset via MTHI/MTLO → 10 busy cycles, out_done pulses, HI/LO still 0x1234/0x5678.
- Stall: start MULT with in_md_use=1 (MFLO in D) → out_stall=1 in start cycle and all 5 busy cycles, 0 in the cycle after commit; with in_md_use=0 → out_stall stays 0.
- MTHI rs=0xDEADBEEF while IDLE → out_hi=0xDEADBEEF next cycle, out_busy stays 0; op=6 → no state change.
